irq_dispatch: RTL and testbench

Interrupt dispatch stage sitting directly downstream of `processor`. It samples the 3-bit priority-encoded request `Q`, the interrupt enable and the 32-bit `data_out` word, queues each new request with its payload in a small FIFO, and presents requests one at a time to the CPU side. The CPU side uses a 4-phase `irq_out`/`ack_in` handshake and receives a computed vector address for each request.

---
 rtl/irq_dispatch.sv | 120 ++++++++++++
 tb/tb_irq_dispatch.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch.sv
// Interrupt dispatch stage: captures new priority requests with their payload into a
// small FIFO and presents them one at a time over a 4-phase irq/ack handshake.
module irq_dispatch #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic [2:0]                   q_in,
  input  logic                         irq_level,
  input  logic                         int_en,
  input  logic [31:0]                  payload_in,
  input  logic                         ack_in,
  input  logic                         clr_ovf,
  output logic                         irq_out,
  output logic [31:0]                  vec_out,
  output logic [31:0]                  payload_out,
  output logic [2:0]                   q_out,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_REL} state_t;

  logic [34:0]   mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic          prevLive_q;
  logic [2:0]    prevQ_q;
  logic          overflow_q;
  state_t        state_q;
  logic          irq_q;
  logic [31:0]   vec_q, payload_q;
  logic [2:0]    qOut_q;

  logic          live, evt, full, pop, push, drop;
  logic [34:0]   head;
  logic [31:0]   headVec;

  // A held request is captured once; a new priority or a re-enable counts as a new event.
  always_comb begin
    live    = int_en & irq_level;
    evt     = live & (~prevLive_q | (q_in != prevQ_q));
    full    = (count_q == CW'(DEPTH));
    pop     = (state_q == IDLE) && (count_q != '0);
    push    = evt && (!full || pop);
    drop    = evt && full && !pop;
    head    = mem_q[rdPtr_q];
    headVec = VEC_BASE + (32'(head[34:32]) << VEC_SHIFT);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= {q_in, payload_in};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      prevLive_q <= 1'b0;
      prevQ_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prevLive_q <= live;
      prevQ_q    <= q_in;
      count_q    <= count_d;
      if (push) wrPtr_q <= wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)         overflow_q <= 1'b1;
      else if (clr_ovf) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vec_q     <= '0;
      payload_q <= '0;
      qOut_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            qOut_q    <= head[34:32];
            payload_q <= head[31:0];
            vec_q     <= headVec;
            irq_q     <= 1'b1;
            state_q   <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack_in) begin
            irq_q   <= 1'b0;
            state_q <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!ack_in) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_out     = irq_q;
  assign vec_out     = vec_q;
  assign payload_out = payload_q;
  assign q_out       = qOut_q;
  assign pending     = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: a cycle table plus hand-written corner sequences,
// with a scoreboard of expected presented requests checked on every irq_out rise.
module tb_irq_dispatch;

  logic        clk = 1'b0;
  logic        rstN;
  logic [2:0]  q_in;
  logic        irq_level, int_en, ack_in, clr_ovf;
  logic [31:0] payload_in;
  logic        irq_out, overflow;
  logic [31:0] vec_out, payload_out;
  logic [2:0]  q_out;
  logic [2:0]  pending;

  irq_dispatch #(.DEPTH(4), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4)) dut (
    .clk(clk), .rstN(rstN), .q_in(q_in), .irq_level(irq_level), .int_en(int_en),
    .payload_in(payload_in), .ack_in(ack_in), .clr_ovf(clr_ovf),
    .irq_out(irq_out), .vec_out(vec_out), .payload_out(payload_out), .q_out(q_out),
    .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        lvl;
    logic [2:0]  q;
    logic [31:0] pay;
    logic        ack;
    logic        cap;
    logic        expIrq;
    int          expPend;
  } vec_t;

  typedef struct {
    logic [2:0]  q;
    logic [31:0] pay;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   nCompared  = 0;
  int   nMismatched = 0;
  logic prevIrq = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic lvl, input logic [2:0] q,
                               input logic [31:0] pay, input logic ack);
    int_en     = en;
    irq_level  = lvl;
    q_in       = q;
    payload_in = pay;
    ack_in     = ack;
  endtask

  task automatic expectPush(input logic [2:0] q, input logic [31:0] pay);
    exp_t e;
    e.q   = q;
    e.pay = pay;
    sb.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later, and score any newly presented request.
  task automatic clockStep();
    exp_t e;
    @(posedge clk);
    #1;
    if (irq_out && !prevIrq) begin
      if (sb.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_irq: got q_out=%0d expected no request at %0t", q_out, $time);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_q_out", 32'(q_out), 32'(e.q));
        checkOutput("sb_payload", payload_out, e.pay);
        checkOutput("sb_vec", vec_out, 32'h0000_0100 + 32'(e.q) * 32'd16);
      end
    end
    prevIrq = irq_out;
  endtask

  task automatic ackAndPresent();
    ack_in = 1'b1;
    clockStep();
    checkOutput("ack_drop_irq", 32'(irq_out), 32'd0);
    ack_in = 1'b0;
    clockStep();
    clockStep();
    checkOutput("next_irq", 32'(irq_out), 32'd1);
  endtask

  task automatic finalAck();
    ack_in = 1'b1;
    clockStep();
    ack_in = 1'b0;
    clockStep();
    clockStep();
    checkOutput("drained_irq", 32'(irq_out), 32'd0);
    checkOutput("drained_pending", 32'(pending), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rstN = 1'b1;
    clr_ovf = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_irq", 32'(irq_out), 32'd0);
    checkOutput("rst_vec", vec_out, 32'd0);
    checkOutput("rst_payload", payload_out, 32'd0);
    checkOutput("rst_q", 32'(q_out), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    clockStep();
    clockStep();
    rstN = 1'b1;

    // Steady Q, Q change, enable toggle, then disabled/level-low inputs.
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'h5555_0001, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'hDEAD_0001, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'hDEAD_0002, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'hDEAD_0003, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'hDEAD_0004, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd5, 32'hDEAD_0005, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h2222_0006, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hDEAD_0007, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b0, 1'b1, 3'd2, 32'hDEAD_0008, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'h2222_0009, 1'b0, 1'b1, 1'b1, 1});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hDEAD_000A, 1'b1, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hDEAD_000B, 1'b0, 1'b0, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hDEAD_000C, 1'b0, 1'b0, 1'b1, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hDEAD_000D, 1'b1, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b1, 3'd2, 32'hDEAD_000E, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 3'd6, 32'hDEAD_000F, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 3'd1, 32'hDEAD_0010, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b0, 1'b1, 3'd4, 32'hDEAD_0011, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 3'd3, 32'hDEAD_0012, 1'b0, 1'b0, 1'b0, 0});
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].en, tbl[i].lvl, tbl[i].q, tbl[i].pay, tbl[i].ack);
      if (tbl[i].cap) expectPush(tbl[i].q, tbl[i].pay);
      clockStep();
      checkOutput($sformatf("tbl%0d_irq", i), 32'(irq_out), 32'(tbl[i].expIrq));
      checkOutput($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].expPend));
    end

    // Single one-cycle request at the highest priority.
    applyStimulus(1'b1, 1'b1, 3'd7, 32'hBBBB_BBBB, 1'b0);
    expectPush(3'd7, 32'hBBBB_BBBB);
    clockStep();
    checkOutput("single_pending", 32'(pending), 32'd1);
    checkOutput("single_irq_e0", 32'(irq_out), 32'd0);
    applyStimulus(1'b0, 1'b0, 3'd7, 32'h0, 1'b0);
    clockStep();
    checkOutput("single_irq_e1", 32'(irq_out), 32'd1);
    checkOutput("single_vec", vec_out, 32'h0000_0170);
    checkOutput("single_payload", payload_out, 32'hBBBB_BBBB);
    finalAck();

    // Overflow: first event presented, next four fill the FIFO, sixth is dropped.
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 1'b1, 3'(k), 32'hA000_0000 | 32'(k), 1'b0);
      if (k <= 5) expectPush(3'(k), 32'hA000_0000 | 32'(k));
      clockStep();
      checkOutput($sformatf("ovf_pending%0d", k), 32'(pending), (k <= 2) ? 32'd1 : ((k >= 5) ? 32'd4 : 32'(k - 1)));
      checkOutput($sformatf("ovf_flag%0d", k), 32'(overflow), (k == 6) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) ackAndPresent();
    finalAck();
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    clockStep();
    clr_ovf = 1'b0;
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    // Full FIFO receives a push on the same edge the idle FSM pops.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 1'b1, 3'(k), 32'hC000_0000 | 32'(k), 1'b0);
      expectPush(3'(k), 32'hC000_0000 | 32'(k));
      clockStep();
    end
    checkOutput("pp_full", 32'(pending), 32'd4);
    ack_in = 1'b1;
    clockStep();
    ack_in = 1'b0;
    clockStep();
    applyStimulus(1'b1, 1'b1, 3'd6, 32'hC000_0006, 1'b0);
    expectPush(3'd6, 32'hC000_0006);
    clockStep();
    checkOutput("pp_pending", 32'(pending), 32'd4);
    checkOutput("pp_overflow", 32'(overflow), 32'd0);
    checkOutput("pp_irq", 32'(irq_out), 32'd1);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) ackAndPresent();
    finalAck();

    // Asynchronous reset while a request is presented and another is queued.
    applyStimulus(1'b1, 1'b1, 3'd1, 32'hE000_0001, 1'b0);
    expectPush(3'd1, 32'hE000_0001);
    clockStep();
    applyStimulus(1'b1, 1'b1, 3'd2, 32'hE000_0002, 1'b0);
    expectPush(3'd2, 32'hE000_0002);
    clockStep();
    checkOutput("mr_irq_before", 32'(irq_out), 32'd1);
    checkOutput("mr_pending_before", 32'(pending), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mr_irq", 32'(irq_out), 32'd0);
    checkOutput("mr_vec", vec_out, 32'd0);
    checkOutput("mr_payload", payload_out, 32'd0);
    checkOutput("mr_q", 32'(q_out), 32'd0);
    checkOutput("mr_pending", 32'(pending), 32'd0);
    sb.delete();
    applyStimulus(1'b1, 1'b1, 3'd3, 32'hE000_0003, 1'b0);
    expectPush(3'd3, 32'hE000_0003);
    #2 rstN = 1'b1;
    clockStep();
    checkOutput("mr_e0_irq", 32'(irq_out), 32'd0);
    checkOutput("mr_e0_pending", 32'(pending), 32'd1);
    clockStep();
    checkOutput("mr_e1_irq", 32'(irq_out), 32'd1);
    checkOutput("mr_e1_q", 32'(q_out), 32'd3);
    checkOutput("mr_e1_vec", vec_out, 32'h0000_0130);
    clockStep();
    clockStep();
    checkOutput("mr_single_capture", 32'(pending), 32'd0);
    finalAck();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
